// File: rtl/display_7seg_mux_pkg.sv
// Shared display constants: blank codes, segment lookup, keypad key codes.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package display_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [3:0] KEY_STAR = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_NONE = CODE_BLANK;

    // Entry [c] is the pattern for code c; code 0xF doubles as the blank code.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b1111111, // F
        7'b0000110, // E
        7'b0100001, // D
        7'b1000110, // C
        7'b0000011, // B
        7'b0001000, // A
        7'b0010000, // 9
        7'b0000000, // 8
        7'b1111000, // 7
        7'b0000010, // 6
        7'b0010010, // 5
        7'b0011001, // 4
        7'b0110000, // 3
        7'b0100100, // 2
        7'b1111001, // 1
        7'b1000000  // 0
    };

endpackage

// File: rtl/display_7seg_mux_if.sv
// Display bus: value and load strobe in, anode and segment pins out.
// Master is the entry/control logic; slave is the display driver.
interface display_7seg_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] valor;
    logic                    cargar;
    logic [NUM_DIGITS-1:0]   anodos;
    logic [6:0]              segmentos;

    modport master (
        output valor,
        output cargar,
        input  anodos,
        input  segmentos
    );

    modport slave (
        input  valor,
        input  cargar,
        output anodos,
        output segmentos
    );
endinterface

// File: rtl/display_7seg_mux_hex_a_7seg.sv
// Hex code to active-low 7-segment pattern; purely combinational.
// No state and no handshake: output follows code_i in the same cycle.
module hex_a_7seg
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[code_i];

endmodule

// File: rtl/display_7seg_mux.sv
// Time-multiplexed common-anode 7-segment driver with optional leading-zero blanking.
// Outputs registered: a load or digit change appears one clk edge later; no backpressure.
module display_7seg_mux
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 13_500,
    parameter int NUM_DIGITS = 4,
    parameter bit BLANK_LZ   = 1'b1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    display_7seg_mux_if.slave    bus
);

    localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   anodos_q, anodos_d;
    logic [6:0]              seg_q;
    logic [6:0]              seg_dec;

    logic                    terminal;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              code_sel;

    assign terminal = (div_q == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        div_d    = terminal ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        shadow_d = bus.cargar ? bus.valor : shadow_q;
    end

    // Walk down from the top digit: a digit is blanked while every nibble
    // from it upward is 0x0. Digit 0 is never blanked so zero shows as "0".
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above && (shadow_q[i*4 +: 4] == 4'h0);
            lz_blank[i] = BLANK_LZ && zero_above;
        end
    end

    always_comb begin
        code_sel = lz_blank[idx_q] ? CODE_BLANK : shadow_q[{idx_q, 2'b00} +: 4];
        anodos_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    hex_a_7seg u_dec (
        .code_i (code_sel),
        .seg_o  (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            idx_q    <= '0;
            shadow_q <= {NUM_DIGITS{CODE_BLANK}};
            anodos_q <= '1;
            seg_q    <= SEG_BLANK;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            anodos_q <= anodos_d;
            seg_q    <= seg_dec;
        end
    end

    assign bus.anodos    = anodos_q;
    assign bus.segmentos = seg_q;

endmodule

// File: tb/tb_display_7seg_mux.sv
// Scoreboard bench for display_7seg_mux: two instances (blanking on and off)
// share one random/directed stimulus stream and are checked every cycle.
module tb_display_7seg_mux;

    localparam int S = 4;
    localparam int N = 4;

    typedef struct packed {
        logic [10:0] lz;
        logic [10:0] nz;
    } exp_t;

    logic clk;
    logic rst_n = 1'b0;

    display_7seg_mux_if #(.NUM_DIGITS(N)) bus_lz ();
    display_7seg_mux_if #(.NUM_DIGITS(N)) bus_nz ();

    display_7seg_mux #(.SCAN_DIV(S), .NUM_DIGITS(N), .BLANK_LZ(1'b1)) dut_lz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lz.slave)
    );

    display_7seg_mux #(.SCAN_DIV(S), .NUM_DIGITS(N), .BLANK_LZ(1'b0)) dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nz.slave)
    );

    logic [15:0] valor  = 16'h0;
    logic        cargar = 1'b0;
    assign bus_lz.valor  = valor;
    assign bus_lz.cargar = cargar;
    assign bus_nz.valor  = valor;
    assign bus_nz.cargar = cargar;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] ref_seg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b1111111
    };

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    logic [15:0] shadow_m = 16'hFFFF;
    exp_t sb [$];

    // Edge e after reset release shows digit ((e-1)/S) mod N from the value
    // loaded on an earlier edge.
    function automatic logic [10:0] model(input logic [15:0] v, input int e, input bit blz);
        int         d;
        logic [3:0] nib;
        logic [3:0] an;
        logic [6:0] seg;
        d   = ((e - 1) / S) % N;
        nib = v[4*d +: 4];
        an  = 4'b1111;
        an[d] = 1'b0;
        if (blz && d > 0 && (v >> (4*d)) == 16'h0) seg = 7'h7F;
        else                                       seg = ref_seg[nib];
        return {an, seg};
    endfunction

    always @(posedge clk) begin
        exp_t x;
        if (!rst_n) begin
            x.lz = {4'b1111, 7'h7F};
            x.nz = {4'b1111, 7'h7F};
            ecount   = 0;
            shadow_m = 16'hFFFF;
        end else begin
            ecount = ecount + 1;
            x.lz = model(shadow_m, ecount, 1'b1);
            x.nz = model(shadow_m, ecount, 1'b0);
            if (cargar) shadow_m = valor;
        end
        sb.push_back(x);
    end

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            x = sb.pop_front();
            checks++;
            if ({bus_lz.anodos, bus_lz.segmentos} !== x.lz) begin
                errors++;
                $display("FAIL out_lz at %0t: got an=%b seg=%b expected an=%b seg=%b",
                         $time, bus_lz.anodos, bus_lz.segmentos, x.lz[10:7], x.lz[6:0]);
            end
            checks++;
            if ({bus_nz.anodos, bus_nz.segmentos} !== x.nz) begin
                errors++;
                $display("FAIL out_nz at %0t: got an=%b seg=%b expected an=%b seg=%b",
                         $time, bus_nz.anodos, bus_nz.segmentos, x.nz[10:7], x.nz[6:0]);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        valor  = v;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic check_dark(input string name);
        checks++;
        if (bus_lz.anodos !== 4'b1111 || bus_lz.segmentos !== 7'h7F ||
            bus_nz.anodos !== 4'b1111 || bus_nz.segmentos !== 7'h7F) begin
            errors++;
            $display("FAIL %s: got an=%b/%b seg=%b/%b expected an=1111 seg=1111111",
                     name, bus_lz.anodos, bus_nz.anodos, bus_lz.segmentos, bus_nz.segmentos);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(2 * S * N);

        load(16'h1234);
        run(2 * S * N);
        load(16'h0070);
        run(S * N + 2);
        load(16'h0000);
        run(S * N + 2);
        load(16'h00F5);
        run(S * N + 2);
        load(16'hF00A);
        run(S * N + 2);

        // Value changes without load must not reach the pins.
        for (int i = 0; i < 2 * S * N; i++) begin
            @(negedge clk);
            valor = 16'($urandom);
        end

        // Load on the terminal-count edge.
        for (int k = 0; k < 3; k++) begin
            while (((ecount + 1) % S) != 0) @(negedge clk);
            valor  = 16'($urandom);
            cargar = 1'b1;
            @(negedge clk);
            cargar = 1'b0;
            run(S + 1);
        end

        for (int c = 0; c < 16; c++) begin
            load(16'(c));
            run(S * N);
        end

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            valor  = 16'($urandom);
            cargar = ($urandom_range(0, 7) == 0);
        end
        cargar = 1'b0;

        // Reset mid-scan: outputs must go dark without waiting for an edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_dark("async_reset");
        run(3);
        rst_n = 1'b1;
        run(S * N + 3);
        load(16'h0409);
        run(2 * S * N);

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
